// File: rtl/bus_arbiter_pkg.sv
// Shared encodings for the two-master bus arbiter.
// FSM state codes, owner codes and the "no strobe" byte-enable value.
// Imported by the arbiter top; rr_pick is self-contained.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_M0   = 2'b01;
  localparam logic [1:0] OWN_M1   = 2'b10;

  localparam logic [3:0] BE_NONE  = 4'b0000;

  // Owner code for a granted master index (0 = m0, 1 = m1).
  function automatic logic [1:0] own_code(input logic id);
    return id ? OWN_M1 : OWN_M0;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational 2-way round-robin pick with an optional held (locked) master.
// Latency: zero cycles, purely combinational.
// No backpressure: the caller decides whether the pick is consumed.
module rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       hold,
  input  logic       held_id,
  output logic       gnt_valid,
  output logic       gnt_id
);

  // Held master wins while it still requests; otherwise the master that was not served last wins a tie.
  always_comb begin
    gnt_valid = |req;
    gnt_id    = 1'b0;
    if (hold && req[held_id]) begin
      gnt_id = held_id;
    end else if (req == 2'b11) begin
      gnt_id = ~last;
    end else begin
      gnt_id = req[1];
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master arbiter serialising CPU and DMA/debug accesses onto one bridge port.
// Latency: req seen in IDLE at t, bridge command at t+1, ack/rdata at t+2; one access per 3 cycles.
// Backpressure: masters hold req and command until their one-cycle ack; the loser simply waits.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_lock,
  input  logic [3:0]        m0_byteen,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_lock,
  input  logic [3:0]        m1_byteen,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [3:0]        s_byteen,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        owner
);

  // Counter only needs to reach MAX_BURST-1; keep at least one bit for MAX_BURST==1.
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  state_t            state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic              gid_q, gid_d;
  logic [3:0]        cmd_be_q, cmd_be_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
  logic              last_q, last_d;
  logic              hold_q, hold_d;
  logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;

  logic [1:0] req_vec;
  logic [1:0] lock_vec;
  logic       gnt_valid;
  logic       gnt_id;

  assign req_vec  = {m1_req, m0_req};
  assign lock_vec = {m1_lock, m0_lock};

  // The held master is always the one served last, so last doubles as held_id.
  rr_pick u_rr_pick (
    .req       (req_vec),
    .last      (last_q),
    .hold      (hold_q),
    .held_id   (last_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // State register: synchronous active-low reset aborts any in-flight access.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_NONE;
      gid_q       <= 1'b0;
      cmd_be_q    <= BE_NONE;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      last_q      <= 1'b1;
      hold_q      <= 1'b0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      gid_q       <= gid_d;
      cmd_be_q    <= cmd_be_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
      last_q      <= last_d;
      hold_q      <= hold_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Next state: grant and capture in IDLE, sample read data in ACCESS, update lock bookkeeping in RESP.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    gid_d       = gid_q;
    cmd_be_d    = cmd_be_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
    last_d      = last_q;
    hold_d      = hold_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      ST_IDLE: begin
        // Held master went away: drop the lock and let normal arbitration run this same cycle.
        if (hold_q && !req_vec[last_q]) begin
          hold_d      = 1'b0;
          burst_cnt_d = '0;
        end
        if (gnt_valid) begin
          state_d     = ST_ACCESS;
          gid_d       = gnt_id;
          owner_d     = own_code(gnt_id);
          cmd_be_d    = gnt_id ? m1_byteen : m0_byteen;
          cmd_addr_d  = gnt_id ? m1_addr   : m0_addr;
          cmd_wdata_d = gnt_id ? m1_wdata  : m0_wdata;
        end
      end
      ST_ACCESS: begin
        if (gid_q) begin
          m1_rdata_d = s_rdata;
        end else begin
          m0_rdata_d = s_rdata;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
        last_d  = gid_q;
        if (lock_vec[gid_q] && (int'(burst_cnt_q) + 1 < MAX_BURST)) begin
          hold_d      = 1'b1;
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end else begin
          hold_d      = 1'b0;
          burst_cnt_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: strobe only in ACCESS, ack only in RESP, both suppressed while reset is asserted.
  always_comb begin
    s_byteen = BE_NONE;
    m0_ack   = 1'b0;
    m1_ack   = 1'b0;
    if (reset) begin
      if (state_q == ST_ACCESS) begin
        s_byteen = cmd_be_q;
      end
      if (state_q == ST_RESP) begin
        m0_ack = ~gid_q;
        m1_ack = gid_q;
      end
    end
  end

  assign s_addr   = cmd_addr_q;
  assign s_wdata  = cmd_wdata_q;
  assign owner    = owner_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus a randomized run.
// Inputs are driven and outputs sampled on the falling edge of clk.
// The random run predicts every cycle from a transaction-level model of the arbitration rules.
module tb_bus_arbiter;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              m0_req = 1'b0, m0_lock = 1'b0;
  logic [3:0]        m0_byteen = '0;
  logic [ADDR_W-1:0] m0_addr = '0;
  logic [DATA_W-1:0] m0_wdata = '0;
  logic              m0_ack;
  logic [DATA_W-1:0] m0_rdata;
  logic              m1_req = 1'b0, m1_lock = 1'b0;
  logic [3:0]        m1_byteen = '0;
  logic [ADDR_W-1:0] m1_addr = '0;
  logic [DATA_W-1:0] m1_wdata = '0;
  logic              m1_ack;
  logic [DATA_W-1:0] m1_rdata;
  logic [3:0]        s_byteen;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;
  logic [DATA_W-1:0] s_rdata = '0;
  logic [1:0]        owner;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_byteen(m0_byteen), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_byteen(m1_byteen), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .s_byteen(s_byteen), .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata),
    .owner(owner)
  );

  task automatic clear_inputs();
    m0_req = 0; m0_lock = 0; m0_byteen = '0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_lock = 0; m1_byteen = '0; m1_addr = '0; m1_wdata = '0;
    s_rdata = '0;
  endtask

  // Ends on a falling edge with reset just released; the next rising edge is the first live IDLE cycle.
  task automatic do_reset();
    @(negedge clk);
    reset = 0;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset = 1;
  endtask

  task automatic test_reset();
    reset = 0;
    clear_inputs();
    m0_req = 1; m0_byteen = 4'hf; m0_addr = 32'h55; m0_wdata = 32'h66;
    repeat (3) @(negedge clk);
    n_chk++; if (owner !== 2'b00) $display("FAIL reset_owner got %h want 0", owner); else n_pass++;
    n_chk++; if (s_byteen !== 4'h0) $display("FAIL reset_byteen got %h want 0", s_byteen); else n_pass++;
    n_chk++; if ({m0_ack, m1_ack} !== 2'b00) $display("FAIL reset_ack got %b want 00", {m0_ack, m1_ack}); else n_pass++;
    n_chk++; if (s_addr !== '0 || s_wdata !== '0) $display("FAIL reset_cmd got %h/%h want 0/0", s_addr, s_wdata); else n_pass++;
    n_chk++; if (m0_rdata !== '0 || m1_rdata !== '0) $display("FAIL reset_rdata got %h/%h want 0/0", m0_rdata, m1_rdata); else n_pass++;
    clear_inputs();
    reset = 1;
  endtask

  task automatic test_single_read();
    do_reset();
    m0_req = 1; m0_addr = 32'h7f04; m0_byteen = 4'h0; m0_wdata = 32'hffff_ffff;
    @(negedge clk);
    n_chk++; if (s_addr !== 32'h7f04) $display("FAIL read_addr got %h want 7f04", s_addr); else n_pass++;
    n_chk++; if (s_byteen !== 4'h0) $display("FAIL read_byteen got %h want 0", s_byteen); else n_pass++;
    n_chk++; if (owner !== 2'b01) $display("FAIL read_owner got %b want 01", owner); else n_pass++;
    s_rdata = 32'h1234;
    @(negedge clk);
    n_chk++; if ({m0_ack, m1_ack} !== 2'b10) $display("FAIL read_ack got m0=%b m1=%b want m0=1 m1=0", m0_ack, m1_ack); else n_pass++;
    n_chk++; if (m0_rdata !== 32'h1234) $display("FAIL read_rdata got %h want 1234", m0_rdata); else n_pass++;
    m0_req = 0; s_rdata = '0;
    @(negedge clk);
    n_chk++; if (m0_ack !== 1'b0 || owner !== 2'b00) $display("FAIL read_after got ack=%b owner=%b want 0/00", m0_ack, owner); else n_pass++;
  endtask

  task automatic test_single_write();
    int be_cycles = 0;
    int ack_at = -1;
    int m0_seen = 0;
    do_reset();
    m1_req = 1; m1_addr = 32'h7f10; m1_wdata = 32'hdeadbeef; m1_byteen = 4'hf;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (s_byteen == 4'hf) be_cycles++;
      if (m0_ack) m0_seen++;
      if (i == 1) begin
        n_chk++;
        if (s_addr !== 32'h7f10 || s_wdata !== 32'hdeadbeef)
          $display("FAIL write_cmd got %h/%h want 7f10/deadbeef", s_addr, s_wdata);
        else n_pass++;
      end
      if (m1_ack && ack_at < 0) begin
        ack_at = i;
        m1_req = 0;
      end
    end
    n_chk++; if (be_cycles != 1) $display("FAIL write_strobe_cycles got %0d want 1", be_cycles); else n_pass++;
    n_chk++; if (ack_at != 2) $display("FAIL write_ack_cycle got %0d want 2", ack_at); else n_pass++;
    n_chk++; if (m0_seen != 0) $display("FAIL write_m0_ack got %0d want 0", m0_seen); else n_pass++;
  endtask

  task automatic test_contention();
    int ack_cyc[$];
    int ack_id[$];
    do_reset();
    m0_req = 1; m0_addr = 32'h100;
    m1_req = 1; m1_addr = 32'h200;
    for (int c = 1; c <= 20 && ack_id.size() < 4; c++) begin
      @(negedge clk);
      if (m0_ack) begin ack_id.push_back(0); ack_cyc.push_back(c); end
      if (m1_ack) begin ack_id.push_back(1); ack_cyc.push_back(c); end
    end
    n_chk++; if (ack_id.size() < 4) $display("FAIL contention_budget got %0d acks want 4", ack_id.size()); else n_pass++;
    for (int i = 0; i < ack_id.size() && i < 4; i++) begin
      n_chk++;
      if (ack_id[i] != i % 2 || ack_cyc[i] != 2 + 3 * i)
        $display("FAIL contention_ack%0d got m%0d@%0d want m%0d@%0d", i, ack_id[i], ack_cyc[i], i % 2, 2 + 3 * i);
      else n_pass++;
    end
    clear_inputs();
  endtask

  task automatic test_lock();
    int ack_id[$];
    int exp_seq[6] = '{1, 1, 1, 1, 0, 1};
    do_reset();
    m1_req = 1; m1_lock = 1; m1_addr = 32'h300;
    for (int c = 1; c <= 40 && ack_id.size() < 6; c++) begin
      @(negedge clk);
      if (c == 1) begin m0_req = 1; m0_addr = 32'h400; end
      if (m0_ack) ack_id.push_back(0);
      if (m1_ack) ack_id.push_back(1);
    end
    n_chk++; if (ack_id.size() < 6) $display("FAIL lock_budget got %0d acks want 6", ack_id.size()); else n_pass++;
    for (int i = 0; i < ack_id.size() && i < 6; i++) begin
      n_chk++;
      if (ack_id[i] != exp_seq[i]) $display("FAIL lock_grant%0d got m%0d want m%0d", i, ack_id[i], exp_seq[i]);
      else n_pass++;
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    m0_req = 1; m0_byteen = 4'h3; m0_addr = 32'h7f20; m0_wdata = 32'h0bad_f00d;
    @(negedge clk);
    n_chk++; if (s_byteen !== 4'h3) $display("FAIL abort_pre_byteen got %h want 3", s_byteen); else n_pass++;
    reset = 0;
    #1;
    n_chk++; if (s_byteen !== 4'h0) $display("FAIL abort_byteen got %h want 0", s_byteen); else n_pass++;
    @(negedge clk);
    m0_req = 0;
    n_chk++; if ({m0_ack, m1_ack} !== 2'b00) $display("FAIL abort_ack got %b want 00", {m0_ack, m1_ack}); else n_pass++;
    n_chk++;
    if (owner !== 2'b00 || s_byteen !== 4'h0 || s_addr !== '0 || s_wdata !== '0 || m0_rdata !== '0)
      $display("FAIL abort_outputs got owner=%b be=%h addr=%h wd=%h rd=%h want all 0", owner, s_byteen, s_addr, s_wdata, m0_rdata);
    else n_pass++;
    @(negedge clk);
    n_chk++; if (m0_ack !== 1'b0) $display("FAIL abort_late_ack got %b want 0", m0_ack); else n_pass++;
    clear_inputs();
    reset = 1;
  endtask

  task automatic test_idle();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_chk++;
      if (owner !== 2'b00 || s_byteen !== 4'h0 || m0_ack !== 1'b0 || m1_ack !== 1'b0)
        $display("FAIL idle_c%0d got owner=%b be=%h ack=%b%b want 00/0/00", i, owner, s_byteen, m0_ack, m1_ack);
      else n_pass++;
    end
  endtask

  // Transaction-level model: a grant decided at cycle k shows on the bridge at k+1, acks at k+2,
  // and the next decision can happen no earlier than k+3.
  task automatic test_random(input int ncyc);
    logic              pend[2];
    logic              c_lock[2];
    logic [3:0]        c_be[2];
    logic [ADDR_W-1:0] c_addr[2];
    logic [DATA_W-1:0] c_wd[2];
    logic [DATA_W-1:0] exp_rd[2];
    logic [3:0]        g_be;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wd;
    logic [DATA_W-1:0] rd_now;
    logic [1:0]        exp_owner;
    logic [3:0]        exp_be;
    int  acc_at = -1, ack_at = -1, free_at = 0, run = 0;
    bit  w = 0, mlast = 1, mhold = 0;
    rd_now = '0; g_be = '0; g_addr = '0; g_wd = '0;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 0; c_lock[i] = 0; c_be[i] = '0; c_addr[i] = '0; c_wd[i] = '0; exp_rd[i] = '0;
    end
    do_reset();
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (k == ack_at) exp_rd[w] = rd_now;
      exp_owner = (k == acc_at || k == ack_at) ? (w ? 2'b10 : 2'b01) : 2'b00;
      exp_be    = (k == acc_at) ? g_be : 4'h0;
      n_chk++; if (owner !== exp_owner) $display("FAIL rnd_owner c%0d got %b want %b", k, owner, exp_owner); else n_pass++;
      n_chk++; if (s_byteen !== exp_be) $display("FAIL rnd_byteen c%0d got %h want %h", k, s_byteen, exp_be); else n_pass++;
      n_chk++;
      if (m0_ack !== (k == ack_at && !w) || m1_ack !== (k == ack_at && w))
        $display("FAIL rnd_ack c%0d got %b%b want %b%b", k, m1_ack, m0_ack, (k == ack_at && w), (k == ack_at && !w));
      else n_pass++;
      n_chk++;
      if (m0_rdata !== exp_rd[0] || m1_rdata !== exp_rd[1])
        $display("FAIL rnd_rdata c%0d got %h/%h want %h/%h", k, m0_rdata, m1_rdata, exp_rd[0], exp_rd[1]);
      else n_pass++;
      if (k == acc_at) begin
        n_chk++;
        if (s_addr !== g_addr || s_wdata !== g_wd)
          $display("FAIL rnd_cmd c%0d got %h/%h want %h/%h", k, s_addr, s_wdata, g_addr, g_wd);
        else n_pass++;
        s_rdata = $urandom;
        rd_now  = s_rdata;
      end
      for (int i = 0; i < 2; i++) begin
        if (k == ack_at && w == i) pend[i] = 0;
        if (!pend[i] && $urandom_range(0, 9) < 6) begin
          pend[i]   = 1;
          c_lock[i] = ($urandom_range(0, 1) == 1);
          c_be[i]   = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
          c_addr[i] = $urandom;
          c_wd[i]   = $urandom;
        end
      end
      m0_req = pend[0]; m0_lock = c_lock[0]; m0_byteen = c_be[0]; m0_addr = c_addr[0]; m0_wdata = c_wd[0];
      m1_req = pend[1]; m1_lock = c_lock[1]; m1_byteen = c_be[1]; m1_addr = c_addr[1]; m1_wdata = c_wd[1];
      // Lock is looked at on the edge closing the ack cycle; a run may reach MAX_BURST grants.
      if (k == ack_at) mhold = c_lock[w] && (run < MAX_BURST);
      if (k >= free_at) begin
        if (pend[0] || pend[1]) begin
          if (mhold && pend[mlast]) begin
            w   = mlast;
            run = run + 1;
          end else begin
            mhold = 0;
            w     = (pend[0] && pend[1]) ? !mlast : pend[1];
            run   = 1;
          end
          mlast   = w;
          g_be    = c_be[w];
          g_addr  = c_addr[w];
          g_wd    = c_wd[w];
          acc_at  = k + 1;
          ack_at  = k + 2;
          free_at = k + 3;
        end else begin
          mhold = 0;
        end
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_lock();
    test_reset_mid_write();
    test_idle();
    test_random(600);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
